mem_burst_arbiter: RTL

MEM_BURST_ARBITER -- requirements
Module: mem_burst_arbiter

---
 rtl/mem_pkg.sv | 20 ++
 rtl/mem_burst_arbiter_if.sv | 43 ++++
 rtl/rr_arbiter2.sv | 12 +
 rtl/mem_burst_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and burst geometry defaults for the memory arbiter
// and the cache modules that talk to it.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BURST_I = 2'd1,
    ST_BURST_D = 2'd2
  } state_t;

  // Values double as bit positions in the one-hot grant vector.
  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  localparam int BURST_LEN_DEF   = 8;
  localparam int BURST_WIDTH_DEF = $clog2(BURST_LEN_DEF);

endpackage

// File: rtl/mem_burst_arbiter_if.sv
// Bundles the instruction-cache, data-cache and RAM sides of the burst arbiter.
interface mem_burst_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20
);
  logic                  inst_req;
  logic [ADDR_WIDTH-1:0] inst_addr;
  logic                  inst_valid;
  logic                  inst_last;
  logic [DATA_WIDTH-1:0] inst_data;

  logic                  data_req;
  logic                  data_rw;
  logic [ADDR_WIDTH-1:0] data_addr;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  data_wnext;
  logic                  data_valid;
  logic                  data_last;
  logic [DATA_WIDTH-1:0] data_rdata;

  logic                  mem_req;
  logic                  mem_rw;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  inst_req, inst_addr, data_req, data_rw, data_addr, data_wdata,
           mem_ack, mem_rdata,
    output inst_valid, inst_last, inst_data, data_wnext, data_valid,
           data_last, data_rdata, mem_req, mem_rw, mem_addr, mem_wdata
  );

  // Environment view: caches plus RAM.
  modport master (
    output inst_req, inst_addr, data_req, data_rw, data_addr, data_wdata,
           mem_ack, mem_rdata,
    input  inst_valid, inst_last, inst_data, data_wnext, data_valid,
           data_last, data_rdata, mem_req, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin: a tie goes to whichever requester did not win last.
module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       req_inst,
  input  logic       req_data,
  input  grant_t     last_grant,
  output logic [1:0] grant
);
  assign grant[GNT_INST] = req_inst & (~req_data | (last_grant == GNT_DATA));
  assign grant[GNT_DATA] = req_data & (~req_inst | (last_grant == GNT_INST));
endmodule

// File: rtl/mem_burst_arbiter.sv
// Shares one word-wide RAM port between I-cache refills and D-cache
// refill/writeback bursts of BURST_LEN words each.
module mem_burst_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_burst_arbiter_if.slave  bus
);
  localparam int BURST_WIDTH = $clog2(BURST_LEN);
  localparam logic [BURST_WIDTH-1:0] CNT_LAST  = BURST_WIDTH'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0]  BASE_MASK = ~ADDR_WIDTH'(BURST_LEN - 1);
  localparam logic [DATA_WIDTH-1:0]  DATA_ZERO = {DATA_WIDTH{1'b0}};

  state_t                 state;
  grant_t                 last_grant;
  logic [BURST_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0]  base;
  logic                   rw;
  logic [1:0]             grant;

  rr_arbiter2 u_rr (
    .req_inst   (bus.inst_req),
    .req_data   (bus.data_req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      last_grant <= GNT_INST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant[GNT_DATA]) begin
            last_grant <= GNT_DATA;
            cnt        <= '0;
            state      <= ST_BURST_D;
          end else if (grant[GNT_INST]) begin
            last_grant <= GNT_INST;
            cnt        <= '0;
            state      <= ST_BURST_I;
          end
        end
        ST_BURST_I, ST_BURST_D: begin
          // Compare before increment so cnt never needs an extra bit.
          if (bus.mem_ack) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Burst address/direction are datapath: only meaningful while a burst is
  // active, and every output that uses them is gated by state.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE) begin
      if (grant[GNT_DATA]) begin
        base <= bus.data_addr & BASE_MASK;
        rw   <= bus.data_rw;
      end else if (grant[GNT_INST]) begin
        base <= bus.inst_addr & BASE_MASK;
        rw   <= 1'b0;
      end
    end
  end

  logic in_i, in_d, d_rd, d_wr, last_word;
  assign in_i      = (state == ST_BURST_I);
  assign in_d      = (state == ST_BURST_D);
  assign d_rd      = in_d & ~rw;
  assign d_wr      = in_d & rw;
  assign last_word = (cnt == CNT_LAST);

  assign bus.mem_req   = in_i | in_d;
  assign bus.mem_rw    = d_wr;
  assign bus.mem_addr  = (in_i | in_d) ? base + ADDR_WIDTH'(cnt) : '0;
  assign bus.mem_wdata = d_wr ? bus.data_wdata : DATA_ZERO;

  assign bus.inst_valid = in_i & bus.mem_ack;
  assign bus.inst_last  = in_i & bus.mem_ack & last_word;
  assign bus.inst_data  = in_i ? bus.mem_rdata : DATA_ZERO;

  assign bus.data_valid = d_rd & bus.mem_ack;
  assign bus.data_wnext = d_wr & bus.mem_ack;
  assign bus.data_last  = in_d & bus.mem_ack & last_word;
  assign bus.data_rdata = d_rd ? bus.mem_rdata : DATA_ZERO;
endmodule
